scaled_frame_display: RTL and testbench

Parametrised framebuffer pixel source for the VGA interface. It maps the raster position (pixel_count, line_count) onto a COLS x ROWS framebuffer. Each framebuffer cell covers 2^SCALE_LOG2 x 2^SCALE_LOG2 screen pixels, and COLS need not be a power of two. Output is registered RGB plus delayed sync/active strobes, all aligned, for the DAC/encoder stage. A single-clock write port lets the drawing engine update the framebuffer.

---
 rtl/display_pkg.sv | 25 ++
 rtl/fb_ram.sv | 26 ++
 rtl/scaled_frame_display.sv | 125 ++++++++++++
 tb/tb_scaled_frame_display.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared pixel-word definitions for the scaled framebuffer display path.
// A pixel word is {R,G,B}, red in the most significant field.
package display_pkg;

  localparam int DEF_COLOR_W = 8;

  typedef struct packed {
    logic [DEF_COLOR_W-1:0] r;
    logic [DEF_COLOR_W-1:0] g;
    logic [DEF_COLOR_W-1:0] b;
  } rgb_t;

  function automatic int red_lsb(input int w);
    return 2 * w;
  endfunction

  function automatic int green_lsb(input int w);
    return w;
  endfunction

  function automatic int blue_lsb(input int w);
    return 0 * w;
  endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port framebuffer memory: one write port, one registered read port,
// single clock, read-first on a same-address collision.
module fb_ram
  import display_pkg::*;
#(
  parameter int DEPTH  = 4800,
  parameter int ADDR_W = 13,
  parameter int DATA_W = 3 * DEF_COLOR_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Both ports in one block with non-blocking updates gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/scaled_frame_display.sv
// Maps the raster position onto a COLS x ROWS framebuffer of 2^SCALE_LOG2-pixel
// cells and emits registered RGB with sync/active strobes delayed to match (latency 2).
module scaled_frame_display
  import display_pkg::*;
#(
  parameter int COLOR_W    = DEF_COLOR_W,
  parameter int COLS       = 80,
  parameter int ROWS       = 60,
  parameter int SCALE_LOG2 = 3,
  parameter int CNT_W      = 10,
  localparam int DEPTH     = COLS * ROWS,
  localparam int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CNT_W-1:0]       pixel_count,
  input  logic [CNT_W-1:0]       line_count,
  input  logic                   active_in,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [3*COLOR_W-1:0]   wr_data,
  input  logic [3*COLOR_W-1:0]   border_color,
  output logic [COLOR_W-1:0]     red,
  output logic [COLOR_W-1:0]     green,
  output logic [COLOR_W-1:0]     blue,
  output logic                   active_out,
  output logic                   hsync_out,
  output logic                   vsync_out,
  output logic                   wr_err
);

  localparam int PIX_W = 3 * COLOR_W;
  localparam int R_LSB = red_lsb(COLOR_W);
  localparam int G_LSB = green_lsb(COLOR_W);
  localparam int B_LSB = blue_lsb(COLOR_W);
  localparam logic [CNT_W-1:0] SUB_MASK = CNT_W'((1 << SCALE_LOG2) - 1);
  localparam logic [ADDR_W:0]  COLS_A   = (ADDR_W + 1)'(COLS);

  logic [CNT_W-1:0]  col;
  logic [CNT_W-1:0]  row;
  logic [ADDR_W:0]   row_base;
  logic [ADDR_W:0]   base_eff;
  logic [ADDR_W:0]   addr_sum;
  logic [ADDR_W-1:0] rd_addr;
  logic              in_range;
  logic              wr_ok;
  logic              s1_in_range;
  logic              s1_active;
  logic              s1_hsync;
  logic              s1_vsync;
  logic [PIX_W-1:0]  rd_data;
  logic [PIX_W-1:0]  pix_sel;

  // Row base steps by COLS at the start of each new cell row instead of multiplying.
  always_comb begin
    col      = pixel_count >> SCALE_LOG2;
    row      = line_count >> SCALE_LOG2;
    base_eff = row_base;
    if (pixel_count == '0) begin
      if (line_count == '0) begin
        base_eff = '0;
      end else if ((line_count & SUB_MASK) == '0) begin
        base_eff = row_base + COLS_A;
      end
    end
    addr_sum = base_eff + (ADDR_W + 1)'(col);
    // A stale base after a raster jump must never address beyond the array.
    rd_addr  = (32'(addr_sum) < DEPTH) ? addr_sum[ADDR_W-1:0] : '0;
    in_range = (32'(col) < COLS) && (32'(row) < ROWS);
    wr_ok    = 32'(wr_addr) < DEPTH;
  end

  // Write port has no ready: a write is taken on every cycle wr_en is high;
  // an out-of-range address is dropped and flagged by wr_err on the next cycle.
  fb_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (PIX_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en && wr_ok),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_comb begin
    pix_sel = '0;
    if (s1_active) pix_sel = s1_in_range ? rd_data : border_color;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_base    <= '0;
      s1_in_range <= 1'b0;
      s1_active   <= 1'b0;
      s1_hsync    <= 1'b0;
      s1_vsync    <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      active_out  <= 1'b0;
      hsync_out   <= 1'b0;
      vsync_out   <= 1'b0;
      wr_err      <= 1'b0;
    end else begin
      row_base    <= base_eff;
      s1_in_range <= in_range;
      s1_active   <= active_in;
      s1_hsync    <= hsync_in;
      s1_vsync    <= vsync_in;
      red         <= pix_sel[R_LSB +: COLOR_W];
      green       <= pix_sel[G_LSB +: COLOR_W];
      blue        <= pix_sel[B_LSB +: COLOR_W];
      active_out  <= s1_active;
      hsync_out   <= s1_hsync;
      vsync_out   <= s1_vsync;
      wr_err      <= wr_en && !wr_ok;
    end
  end

endmodule

// File: tb/tb_scaled_frame_display.sv
// Bench for scaled_frame_display: an 80x60 x8-scaled instance for directed cases and
// a 50x12 unscaled instance swept over full frames against a behavioural model.
module tb_scaled_frame_display;
  import display_pkg::*;

  localparam int A_COLS = 80, A_ROWS = 60, A_S = 3, A_DEPTH = 4800, A_AW = 13;
  localparam int B_COLS = 50, B_ROWS = 12, B_S = 0, B_DEPTH = 600, B_AW = 10;
  localparam int B_HTOT = 56, B_VTOT = 14;
  localparam rgb_t C_RED   = '{r: 8'hFF, g: 8'h00, b: 8'h00};
  localparam rgb_t C_GREEN = '{r: 8'h00, g: 8'hFF, b: 8'h00};

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [9:0]      a_pix, a_line, b_pix, b_line;
  logic            a_act, a_hs, a_vs, b_act, b_hs, b_vs;
  logic            a_we, b_we;
  logic [A_AW-1:0] a_wa;
  logic [B_AW-1:0] b_wa;
  logic [23:0]     a_wd, b_wd, a_border, b_border;
  logic [7:0]      a_red, a_green, a_blue, b_red, b_green, b_blue;
  logic            a_act_o, a_hs_o, a_vs_o, a_err, b_act_o, b_hs_o, b_vs_o, b_err;

  scaled_frame_display #(.COLOR_W(8), .COLS(A_COLS), .ROWS(A_ROWS), .SCALE_LOG2(A_S), .CNT_W(10)) u_a (
    .clk(clk), .rst_n(rst_n), .pixel_count(a_pix), .line_count(a_line),
    .active_in(a_act), .hsync_in(a_hs), .vsync_in(a_vs),
    .wr_en(a_we), .wr_addr(a_wa), .wr_data(a_wd), .border_color(a_border),
    .red(a_red), .green(a_green), .blue(a_blue),
    .active_out(a_act_o), .hsync_out(a_hs_o), .vsync_out(a_vs_o), .wr_err(a_err)
  );

  scaled_frame_display #(.COLOR_W(8), .COLS(B_COLS), .ROWS(B_ROWS), .SCALE_LOG2(B_S), .CNT_W(10)) u_b (
    .clk(clk), .rst_n(rst_n), .pixel_count(b_pix), .line_count(b_line),
    .active_in(b_act), .hsync_in(b_hs), .vsync_in(b_vs),
    .wr_en(b_we), .wr_addr(b_wa), .wr_data(b_wd), .border_color(b_border),
    .red(b_red), .green(b_green), .blue(b_blue),
    .active_out(b_act_o), .hsync_out(b_hs_o), .vsync_out(b_vs_o), .wr_err(b_err)
  );

  // scoreboard
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, got, want);
    end
  endtask

  // Behavioural model: what the sampled pixel shows, by plain cell arithmetic.
  typedef struct packed {
    logic act, hs, vs, inr, known;
    logic [23:0] data;
  } stage_t;

  typedef struct packed {
    logic act, hs, vs, err, rgb_chk;
    logic [23:0] rgb;
  } exp_t;

  logic [23:0] mem_a [int];
  logic [23:0] mem_b [int];
  stage_t a_s1, b_s1;
  exp_t   a_e, b_e;

  function automatic exp_t to_out(input stage_t s, input logic [23:0] border, input logic err);
    exp_t e;
    e.act = s.act; e.hs = s.hs; e.vs = s.vs; e.err = err;
    if (!s.act) begin
      e.rgb = '0; e.rgb_chk = 1'b1;
    end else if (!s.inr) begin
      e.rgb = border; e.rgb_chk = 1'b1;
    end else begin
      e.rgb = s.data; e.rgb_chk = s.known;
    end
    return e;
  endfunction

  task automatic chk_out(input string tag, input exp_t e, input logic [23:0] rgb,
                         input logic act, input logic hs, input logic vs, input logic err);
    chk({tag, "_active_out"}, 32'(act), 32'(e.act));
    chk({tag, "_hsync_out"}, 32'(hs), 32'(e.hs));
    chk({tag, "_vsync_out"}, 32'(vs), 32'(e.vs));
    chk({tag, "_wr_err"}, 32'(err), 32'(e.err));
    if (e.rgb_chk) chk({tag, "_rgb"}, 32'(rgb), 32'(e.rgb));
  endtask

  // compare process
  always @(posedge clk) begin
    int col, row, addr;
    if (!rst_n) begin
      a_s1 = '0; b_s1 = '0;
      a_e = '0; a_e.rgb_chk = 1'b1;
      b_e = '0; b_e.rgb_chk = 1'b1;
    end else begin
      a_e = to_out(a_s1, a_border, a_we && int'(a_wa) >= A_DEPTH);
      col = int'(a_pix) / (1 << A_S);
      row = int'(a_line) / (1 << A_S);
      addr = row * A_COLS + col;
      a_s1.act = a_act; a_s1.hs = a_hs; a_s1.vs = a_vs;
      a_s1.inr = (col < A_COLS) && (row < A_ROWS);
      a_s1.known = a_s1.inr && mem_a.exists(addr);
      a_s1.data = a_s1.known ? mem_a[addr] : 24'h0;
      if (a_we && int'(a_wa) < A_DEPTH) mem_a[int'(a_wa)] = a_wd;

      b_e = to_out(b_s1, b_border, b_we && int'(b_wa) >= B_DEPTH);
      col = int'(b_pix) / (1 << B_S);
      row = int'(b_line) / (1 << B_S);
      addr = row * B_COLS + col;
      b_s1.act = b_act; b_s1.hs = b_hs; b_s1.vs = b_vs;
      b_s1.inr = (col < B_COLS) && (row < B_ROWS);
      b_s1.known = b_s1.inr && mem_b.exists(addr);
      b_s1.data = b_s1.known ? mem_b[addr] : 24'h0;
      if (b_we && int'(b_wa) < B_DEPTH) mem_b[int'(b_wa)] = b_wd;
    end
    #1;
    chk_out("a", a_e, {a_red, a_green, a_blue}, a_act_o, a_hs_o, a_vs_o, a_err);
    chk_out("b", b_e, {b_red, b_green, b_blue}, b_act_o, b_hs_o, b_vs_o, b_err);
  end

  // driver tasks
  task automatic a_write(input int addr, input logic [23:0] d);
    @(negedge clk); a_we = 1'b1; a_wa = A_AW'(addr); a_wd = d;
    @(negedge clk); a_we = 1'b0;
  endtask

  // Walk the raster from (0,0) through each cell-row start so the row base is valid,
  // then present the target pixel and check the registered result two clocks later.
  task automatic read_a(input int pix, input int line, input logic act,
                        input logic [23:0] want, input string name);
    int last_r;
    last_r = (pix == 0 && line > 0) ? (line - 1) / (1 << A_S) : line / (1 << A_S);
    @(negedge clk); a_pix = '0; a_line = '0; a_act = 1'b0; a_hs = 1'b0;
    for (int r = 1; r <= last_r; r++) begin
      @(negedge clk); a_line = 10'(r * (1 << A_S));
    end
    @(negedge clk); a_pix = 10'(pix); a_line = 10'(line); a_act = act; a_hs = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk({name, "_rgb"}, 32'({a_red, a_green, a_blue}), 32'(want));
    chk({name, "_active"}, 32'(a_act_o), 32'(act));
    chk({name, "_hsync"}, 32'(a_hs_o), 32'h1);
  endtask

  initial begin
    a_pix = '0; a_line = '0; a_act = 0; a_hs = 0; a_vs = 0; a_we = 0; a_wa = '0; a_wd = '0;
    b_pix = '0; b_line = '0; b_act = 0; b_hs = 0; b_vs = 0; b_we = 0; b_wa = '0; b_wd = '0;
    a_border = 24'h123456;
    b_border = 24'h0000FF;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: mid-raster reset held 5 cycles, inputs constant
    for (int p = 100; p < 110; p++) begin
      @(negedge clk); a_pix = 10'(p); a_line = 10'd50; a_act = 1'b1; a_hs = 1'b1; a_vs = 1'b1;
    end
    @(posedge clk); #1;
    chk("t1_active_before_reset", 32'(a_act_o), 32'h1);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("t1_async_rgb", 32'({a_red, a_green, a_blue}), 32'h0);
    chk("t1_async_strobes", 32'({a_act_o, a_hs_o, a_vs_o}), 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t1_held_outputs", 32'({a_red, a_green, a_blue, a_act_o, a_hs_o, a_vs_o, a_err}), 32'h0);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("t1_wr_err_quiet", 32'(a_err), 32'h0);
    end
    @(negedge clk); a_vs = 1'b0;

    // 2: cell mapping
    a_write(0, C_RED);
    a_write(82, C_GREEN);
    read_a(16, 8, 1'b1, C_GREEN, "t2_cell_c2_r1");
    read_a(23, 15, 1'b1, C_GREEN, "t2_cell_c2_r1_last_px");
    read_a(0, 7, 1'b1, C_RED, "t2_cell_c0_r0");

    // 3: border and blanking
    read_a(640, 0, 1'b1, 24'h123456, "t3_border_col80");
    read_a(640, 0, 1'b0, 24'h000000, "t3_inactive_blank");
    read_a(8, 480, 1'b1, 24'h123456, "t3_border_row60");

    // 4: rejected writes
    a_write(4799, 24'hC0FFEE);
    @(negedge clk); a_we = 1'b1; a_wa = A_AW'(A_DEPTH); a_wd = 24'hDEAD00;
    @(posedge clk); #1;
    chk("t4_wr_err_pulse", 32'(a_err), 32'h1);
    @(negedge clk); a_we = 1'b0;
    @(posedge clk); #1;
    chk("t4_wr_err_one_cycle", 32'(a_err), 32'h0);
    @(negedge clk); a_we = 1'b1; a_wa = A_AW'(8191); a_wd = 24'hDEAD01;
    @(posedge clk); #1;
    chk("t4_wr_err_max_addr", 32'(a_err), 32'h1);
    @(negedge clk); a_we = 1'b0;
    read_a(632, 472, 1'b1, 24'hC0FFEE, "t4_readback_4799");

    // 5: read-first collision on address 5 (col 5, row 0)
    a_write(5, 24'hAAAAAA);
    read_a(40, 0, 1'b1, 24'hAAAAAA, "t5_before");
    @(negedge clk); a_pix = 10'd40; a_line = 10'd0; a_act = 1'b1;
    a_we = 1'b1; a_wa = A_AW'(5); a_wd = 24'h555555;
    @(negedge clk); a_we = 1'b0;
    @(posedge clk); #1;
    chk("t5_collision_old", 32'({a_red, a_green, a_blue}), 32'hAAAAAA);
    @(posedge clk); #1;
    chk("t5_next_new", 32'({a_red, a_green, a_blue}), 32'h555555);
    @(negedge clk); a_act = 1'b0; a_hs = 1'b0; a_pix = '0; a_line = '0;

    // 6: unscaled, non-power-of-two width; fill value = address, then two frames
    for (int i = 0; i < B_DEPTH; i++) begin
      @(negedge clk); b_we = 1'b1; b_wa = B_AW'(i); b_wd = 24'(i);
    end
    @(negedge clk); b_we = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int l = 0; l < B_VTOT; l++) begin
        for (int p = 0; p < B_HTOT; p++) begin
          @(negedge clk);
          b_pix = 10'(p); b_line = 10'(l);
          b_act = (p < 52) && (l < 13);
          b_hs = (p >= 53) && (p <= 54);
          b_vs = (l == 13);
        end
      end
    end
    @(negedge clk); b_pix = '0; b_line = '0; b_act = 0; b_hs = 0; b_vs = 0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
